// File: rtl/cereal_arb.sv
// Round-robin arbiter granting four byte requesters access to one serial transmitter.
// Optional transmit watchdog enabled by defining CEREAL_ARB_TIMEOUT_EN.
module cereal_arb #(
    parameter logic [19:0] TIMEOUT = 20'd800000
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  done,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_status,
    output logic        busy,
    output logic [3:0]  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_READY,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [1:0]  last_q;
    logic [1:0]  win_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic [3:0]  done_q;
    logic [1:0]  pick_d;
    logic        found_d;
    logic [1:0]  cand;

    // Scan from last+1 upward; k=4 wraps back onto last so it is considered last.
    always_comb begin
        pick_d  = 2'd0;
        found_d = 1'b0;
        cand    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found_d && req[cand]) begin
                pick_d  = cand;
                found_d = 1'b1;
            end
        end
    end

`ifdef CEREAL_ARB_TIMEOUT_EN
    logic [19:0] cnt_q;
    logic [3:0]  err_q;
`endif

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= 2'd3;
            win_q      <= 2'd0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            done_q     <= 4'b0000;
`ifdef CEREAL_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 4'b0000;
`endif
        end else begin
            done_q <= 4'b0000;
`ifdef CEREAL_ARB_TIMEOUT_EN
            err_q  <= 4'b0000;
`endif
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        win_q      <= pick_d;
                        tx_data_q  <= req_data[{pick_d, 3'b000} +: 8];
                        tx_start_q <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: state_q <= S_WAIT_BUSY;
                S_WAIT_BUSY: begin
                    if (!tx_status) begin
                        tx_start_q <= 1'b0;
                        state_q    <= S_WAIT_READY;
                    end
                end
                S_WAIT_READY: begin
                    if (tx_status) begin
                        done_q  <= 4'b0001 << win_q;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_q  <= win_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef CEREAL_ARB_TIMEOUT_EN
            // Watchdog overrides the case above when it fires.
            if (state_q == S_START || state_q == S_WAIT_BUSY) begin
                cnt_q <= cnt_q + 20'd1;
                if (cnt_q == TIMEOUT - 20'd1) begin
                    tx_start_q <= 1'b0;
                    err_q      <= 4'b0001 << win_q;
                    last_q     <= win_q;
                    state_q    <= S_IDLE;
                end
            end else begin
                cnt_q <= '0;
            end
`endif
        end
    end

    assign done     = done_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = (state_q != S_IDLE);
`ifdef CEREAL_ARB_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 4'b0000;
`endif

endmodule

// File: tb/tb_cereal_arb.sv
// Bench for cereal_arb: vector table plus scoreboard of expected grants, with a
// behavioural transmitter that drops/raises tx_status after programmable delays.
module tb_cereal_arb;

    logic        sysclk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  done;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_status;
    logic        busy;
    logic [3:0]  err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    int drop_dly = 3;
    int blen     = 10;
    bit no_resp  = 1'b0;
    int mph      = 0;
    int mcnt     = 0;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] dat;
        int         starts;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0]  rq;
        logic [31:0] data;
        int          drop;
        int          bl;
        logic [1:0]  idx;
        logic [7:0]  dat;
    } vec_t;
    vec_t vt[8];

    cereal_arb #(.TIMEOUT(20'd20)) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .done     (done),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_status(tx_status),
        .busy     (busy),
        .err      (err)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transmitter model: goes busy drop_dly cycles after seeing tx_start, ready blen cycles later.
    initial begin
        tx_status = 1'b1;
        forever begin
            @(negedge sysclk);
            if (rst) begin
                mph = 0;
                tx_status = 1'b1;
            end else if (mph == 0) begin
                if (tx_start && !no_resp) begin
                    mph = 1;
                    mcnt = 0;
                end
            end else if (mph == 1) begin
                mcnt++;
                if (mcnt >= drop_dly) begin
                    tx_status = 1'b0;
                    mph = 2;
                    mcnt = 0;
                end
            end else begin
                mcnt++;
                if (mcnt >= blen) begin
                    tx_status = 1'b1;
                    mph = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        int  scnt;
        bit  prev_done;
        exp_t e;
        scnt = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge sysclk);
            #2;
            if (rst) begin
                scnt = 0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) chk("gap_busy", {31'd0, busy}, 32'd0);
                if (tx_start) scnt++;
                if (done != 4'b0000) begin
                    if (sb.size() == 0) begin
                        vec_cnt++;
                        miss_cnt++;
                        $display("FAIL unexpected_done: got %b expected none at %0t", done, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("done_vec",   {28'd0, done}, 32'd1 << e.idx);
                        chk("tx_data",    {24'd0, tx_data}, {24'd0, e.dat});
                        chk("start_len",  scnt, e.starts);
                        chk("busy_done",  {31'd0, busy}, 32'd1);
                        chk("err_w_done", {28'd0, err}, 32'd0);
                    end
                    scnt = 0;
                end
                if (err != 4'b0000) scnt = 0;
                prev_done = (done != 4'b0000);
            end
        end
    end

    task automatic wait_done(input int n);
        int seen = 0;
        for (int c = 0; c < 400 && seen < n; c++) begin
            @(negedge sysclk);
            if (done != 4'b0000) seen++;
        end
        if (seen < n) chk("done_timeout", seen, n);
    endtask

    // Return mid-WAIT_READY: the cycle after busy is seen with tx_start low.
    task automatic wait_wr();
        bit ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge sysclk);
            if (busy && !tx_start && done == 4'b0000) ok = 1'b1;
        end
        if (!ok) chk("wr_timeout", 0, 1);
        @(negedge sysclk);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        rst = 1'b1;
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{4'b0001, 32'h000000A5, 3, 10, 2'd0, 8'hA5};
        vt[1] = '{4'b0101, 32'h00CC00BB, 1, 1,  2'd2, 8'hCC};
        vt[2] = '{4'b0101, 32'h00CC00BB, 2, 4,  2'd0, 8'hBB};
        vt[3] = '{4'b0101, 32'h00CC00BB, 3, 2,  2'd2, 8'hCC};
        vt[4] = '{4'b1000, 32'h7E000000, 1, 5,  2'd3, 8'h7E};
        vt[5] = '{4'b1010, 32'h5A003C00, 2, 1,  2'd1, 8'h3C};
        vt[6] = '{4'b1010, 32'h5A003C00, 4, 3,  2'd3, 8'h5A};
        vt[7] = '{4'b0110, 32'h00667700, 1, 2,  2'd1, 8'h77};

        rst = 1'b1;
        req = 4'b0000;
        req_data = 32'h0;
        #1;
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data",  {24'd0, tx_data}, 32'd0);
        chk("rst_done",     {28'd0, done}, 32'd0);
        chk("rst_err",      {28'd0, err}, 32'd0);
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        @(negedge sysclk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // All requesters held: fair rotation 0,1,2,3,0.
        drop_dly = 2;
        blen = 3;
        req_data = 32'h44332211;
        req = 4'b1111;
        sb.push_back('{2'd0, 8'h11, 3});
        sb.push_back('{2'd1, 8'h22, 3});
        sb.push_back('{2'd2, 8'h33, 3});
        sb.push_back('{2'd3, 8'h44, 3});
        sb.push_back('{2'd0, 8'h11, 3});
        wait_done(5);
        req = 4'b0000;
        @(negedge sysclk);

        do_reset();
        @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            drop_dly = vt[i].drop;
            blen = vt[i].bl;
            req_data = vt[i].data;
            req = vt[i].rq;
            sb.push_back('{vt[i].idx, vt[i].dat, vt[i].drop + 1});
            wait_done(1);
            req = 4'b0000;
            @(negedge sysclk);
        end

        // Payload and request withdrawn mid-transfer: original byte still completes.
        drop_dly = 2;
        blen = 6;
        req_data = 32'h000000C3;
        req = 4'b0001;
        sb.push_back('{2'd0, 8'hC3, 3});
        wait_wr();
        req = 4'b0000;
        req_data = 32'hFFFFFFFF;
        chk("hold_tx_data", {24'd0, tx_data}, 32'hC3);
        wait_done(1);
        @(negedge sysclk);

        // Reset in WAIT_READY abandons the byte; arbitration restarts from requester 0.
        drop_dly = 1;
        blen = 8;
        req_data = 32'h99000000;
        req = 4'b1000;
        wait_wr();
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("mid_rst_busy",     {31'd0, busy}, 32'd0);
        chk("mid_rst_done",     {28'd0, done}, 32'd0);
        req = 4'b0100;
        req_data = 32'h00550000;
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        sb.push_back('{2'd2, 8'h55, 2});
        wait_done(1);
        req = 4'b0000;
        @(negedge sysclk);

`ifdef CEREAL_ARB_TIMEOUT_EN
        begin
            int  tc;
            bit  seen;
            no_resp = 1'b1;
            req_data = 32'h0000D200;
            req = 4'b0010;
            seen = 1'b0;
            for (int c = 0; c < 50 && !seen; c++) begin
                @(negedge sysclk);
                if (tx_start) seen = 1'b1;
            end
            req = 4'b0000;
            tc = 0;
            seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge sysclk);
                tc++;
                if (err != 4'b0000) seen = 1'b1;
            end
            chk("tmo_cycles",   tc, 20);
            chk("tmo_err",      {28'd0, err}, 32'b0010);
            chk("tmo_done",     {28'd0, done}, 32'd0);
            chk("tmo_busy",     {31'd0, busy}, 32'd0);
            chk("tmo_tx_start", {31'd0, tx_start}, 32'd0);
            no_resp = 1'b0;
            @(negedge sysclk);
        end
`endif

        repeat (4) @(negedge sysclk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
